ram128_arb: RTL and testbench
=============================

RAM128_ARB -- requirements
Module: ram128_arb

Interface
REQ-001 SHALL have parameter INIT_VAL, default 1'b0: the value written to every RAM location during the init sweep.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port a_req, input, 1 bit: requester A transaction request, held until a_gnt.
REQ-005 SHALL have port a_we, input, 1 bit: requester A operation, 1 = write, 0 = read.
REQ-006 SHALL have port a_addr, input, 7 bits: requester A RAM address.
REQ-007 SHALL have port a_wd, input, 1 bit: requester A write data.
REQ-008 SHALL have port a_gnt, output, 1 bit: single-cycle grant; the transaction executes in this cycle.
REQ-009 SHALL have port a_rvalid, output, 1 bit: read data valid, a one-cycle pulse.
REQ-010 SHALL have port a_rdata, output, 1 bit: requester A read data.
REQ-011 SHALL have ports b_req, b_we, b_addr[6:0], b_wd, b_gnt, b_rvalid and b_rdata, identical in direction, width and meaning to the A ports.
REQ-012 SHALL have port ram_we, output, 1 bit: drives the RAM write enable.
REQ-013 SHALL have port ram_a, output, 7 bits: drives the RAM address.
REQ-014 SHALL have port ram_d, output, 1 bit: drives the RAM write data.
REQ-015 SHALL have port ram_spo, input, 1 bit: the RAM's asynchronous read data at ram_a.
REQ-016 SHALL have port busy, output, 1 bit: high while the init sweep runs.

Function
REQ-017 SHALL implement a two-state FSM with states INIT and SERVE.
REQ-018 In INIT, SHALL drive ram_we=1, ram_a=cnt and ram_d=INIT_VAL, and SHALL hold busy=1 and all gnt=0.
REQ-019 In INIT, SHALL increment cnt each cycle from 0 and move to SERVE after the cycle with cnt=127, giving exactly 128 cycles.
REQ-020 In SERVE, SHALL grant at most one requester per cycle, with gnt generated combinationally from req and the priority pointer.
REQ-021 With a single request, SHALL grant that requester in the same cycle.
REQ-022 With both requests asserted, SHALL grant the requester indicated by the priority pointer (ptr=0 means A).
REQ-023 SHALL update ptr on every grant to point at the other requester; with no grant, ptr holds.
REQ-024 During a grant cycle, SHALL drive ram_a, ram_we and ram_d from the granted requester's addr, we and wd.
REQ-025 During a grant cycle, the RAM write SHALL occur at the closing clock edge.
REQ-026 With no grant in SERVE, SHALL drive ram_we=0 and ram_a=0.
REQ-027 For a read grant, SHALL register ram_spo into x_rdata at the grant-closing edge and pulse x_rvalid high for the following cycle: latency 1.
REQ-028 x_rdata SHALL hold its value until the next read completes for that requester.
REQ-029 A write grant SHALL NOT assert rvalid.
REQ-030 A read granted the cycle after a write to the same address SHALL return the new data.
REQ-031 Under continuous requests from both A and B, grants SHALL alternate A,B,A,B; no requester waits more than 1 cycle.
REQ-032 req sampled in INIT SHALL be ignored, with no grant, and served once in SERVE if still held.

Reset
REQ-033 On rst_n=0, SHALL asynchronously set state=INIT, cnt=0, ptr=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0 and busy=1; all gnt SHALL be 0.
REQ-034 Reset mid-sweep or mid-transaction SHALL abort it; the sweep restarts from address 0 after release, and no pending rvalid pulse is issued.

Configuration
REQ-035 Macro RAM128_ARB_INIT_EN defined: the INIT sweep is compiled in as specified above.
REQ-036 Macro RAM128_ARB_INIT_EN undefined: the INIT state and cnt SHALL be absent, reset SHALL enter SERVE directly, busy SHALL be tied 0, and RAM contents after reset SHALL be unspecified.

Verification
REQ-037 SHALL verify reset release with INIT_EN defined: busy=1 for exactly 128 cycles, ram_we=1, ram_a sequencing 0..127 with ram_d=0, then busy=0.
REQ-038 SHALL verify a single requester: A writes addr 0x15 wd=1, then A reads 0x15 in the next cycle: a_gnt both cycles and a_rvalid=1 with a_rdata=1 one cycle after the read grant.
REQ-039 SHALL verify contention: A and B held requesting for 6 cycles with ptr=0: gnt sequence A,B,A,B,A,B and no double grant.
REQ-040 SHALL verify cross-requester coherence: B writes 0x7F=1, then A reads 0x7F the next cycle: a_rdata=1, with b_rvalid staying 0.
REQ-041 SHALL verify reset mid-sweep: rst_n low at cnt=50: outputs at reset values immediately, and the sweep restarts at ram_a=0.
REQ-042 SHALL verify a request during INIT: a_req held from cycle 10: no a_gnt until the first SERVE cycle, then exactly one grant.

Source files
------------

// File: rtl/ram128_arb_if.sv
// ram128_arb_if -- requester bus for the two-port 128x1 RAM arbiter.
//
// Carries both requesters' transaction signals, named a_* for requester A and
// b_* for requester B.
//   x_req    : transaction request, held until x_gnt
//   x_we     : 1 = write, 0 = read
//   x_addr   : 7-bit RAM address
//   x_wd     : write data
//   x_gnt    : single-cycle grant; the transaction executes in that cycle
//   x_rvalid : one-cycle pulse, the cycle after a read grant
//   x_rdata  : read data, held until that requester's next read completes
// Modports: master = requester side, slave = arbiter side.
interface ram128_arb_if;
  logic       a_req;
  logic       a_we;
  logic [6:0] a_addr;
  logic       a_wd;
  logic       a_gnt;
  logic       a_rvalid;
  logic       a_rdata;

  logic       b_req;
  logic       b_we;
  logic [6:0] b_addr;
  logic       b_wd;
  logic       b_gnt;
  logic       b_rvalid;
  logic       b_rdata;

  modport master (
    output a_req, a_we, a_addr, a_wd,
    output b_req, b_we, b_addr, b_wd,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wd,
    input  b_req, b_we, b_addr, b_wd,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata
  );
endinterface

// File: rtl/ram128_arb.sv
// ram128_arb -- round-robin arbiter giving two requesters access to one
// external 128x1 RAM with asynchronous read, plus an optional init sweep.
//
// Build option: define RAM128_ARB_INIT_EN to compile in the INIT state, which
// writes INIT_VAL to all 128 locations after reset (busy=1 for 128 cycles).
// Without it the arbiter serves from the first cycle after reset, busy is tied
// low and the RAM contents after reset are whatever the RAM holds.
//
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : requester bus (ram128_arb_if.slave), requesters A and B
//   ram_we     : RAM write enable
//   ram_a      : RAM address
//   ram_d      : RAM write data
//   ram_spo    : RAM asynchronous read data at ram_a
//   busy       : high while the init sweep runs
module ram128_arb #(
  parameter logic INIT_VAL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  ram128_arb_if.slave bus,
  output logic        ram_we,
  output logic [6:0]  ram_a,
  output logic        ram_d,
  input  logic        ram_spo,
  output logic        busy
);

  logic serve;     // arbiter may grant this cycle
  logic ptr;       // tie-break: 0 favours A, 1 favours B
  logic gnt_a;
  logic gnt_b;
  logic a_rvalid_q;
  logic a_rdata_q;
  logic b_rvalid_q;
  logic b_rdata_q;

`ifdef RAM128_ARB_INIT_EN
  typedef enum logic {INIT, SERVE} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [6:0] cnt;
  logic [6:0] cnt_nxt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every always_comb output gets a default before any branch; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == INIT) begin
      cnt_nxt = cnt + 7'd1;
      if (cnt == 7'd127) state_nxt = SERVE;
    end
  end

  assign serve = (state == SERVE);
`else
  assign serve = 1'b1;
`endif

  // A lone request wins outright; a tie goes to the side ptr points at.
  // rst_n gates the grants so nothing is granted while reset is held, which
  // matters when the INIT state is compiled out.
  assign gnt_a = rst_n & serve & bus.a_req & (~bus.b_req | ~ptr);
  assign gnt_b = rst_n & serve & bus.b_req & (~bus.a_req |  ptr);

  assign bus.a_gnt    = gnt_a;
  assign bus.b_gnt    = gnt_b;
  assign bus.a_rvalid = a_rvalid_q;
  assign bus.a_rdata  = a_rdata_q;
  assign bus.b_rvalid = b_rvalid_q;
  assign bus.b_rdata  = b_rdata_q;

  // RAM port mux: the granted requester drives the RAM for its cycle; with no
  // grant the RAM sees a harmless read of address 0.
  always_comb begin
    ram_we = 1'b0;
    ram_a  = '0;
    ram_d  = INIT_VAL;
    busy   = 1'b0;
    if (gnt_a) begin
      ram_we = bus.a_we;
      ram_a  = bus.a_addr;
      ram_d  = bus.a_wd;
    end else if (gnt_b) begin
      ram_we = bus.b_we;
      ram_a  = bus.b_addr;
      ram_d  = bus.b_wd;
    end
`ifdef RAM128_ARB_INIT_EN
    if (state == INIT) begin
      ram_we = 1'b1;
      ram_a  = cnt;
      ram_d  = INIT_VAL;
      busy   = 1'b1;
    end
`endif
  end

  // Pointer flips to the other requester on every grant. Read data is taken
  // from ram_spo at the edge that closes the grant cycle, so rvalid/rdata
  // appear one cycle after the grant; a write at that same edge is visible to
  // a read granted in the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= 1'b0;
      a_rvalid_q <= 1'b0;
      a_rdata_q  <= 1'b0;
      b_rvalid_q <= 1'b0;
      b_rdata_q  <= 1'b0;
    end else begin
      if (gnt_a)      ptr <= 1'b1;
      else if (gnt_b) ptr <= 1'b0;

      a_rvalid_q <= gnt_a & ~bus.a_we;
      b_rvalid_q <= gnt_b & ~bus.b_we;
      if (gnt_a & ~bus.a_we) a_rdata_q <= ram_spo;
      if (gnt_b & ~bus.b_we) b_rdata_q <= ram_spo;
    end
  end

endmodule

// File: tb/tb_ram128_arb.sv
// tb_ram128_arb -- self-checking bench for ram128_arb.
//
// Holds a 128x1 asynchronous-read RAM attached to the DUT's RAM port, and a
// reference model: the expected RAM contents, which requester wins a tie, and
// the read result expected one cycle after each read grant. Directed steps
// cover reset, the init sweep (when RAM128_ARB_INIT_EN is defined), single
// requester write/read, contention, cross-requester coherence, and reset
// mid-transaction; a random phase follows. Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge.
module tb_ram128_arb;

`ifdef RAM128_ARB_INIT_EN
  localparam bit INIT_ON = 1'b1;
`else
  localparam bit INIT_ON = 1'b0;
`endif
  localparam bit INIT_VAL = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ram_we;
  logic [6:0] ram_a;
  logic       ram_d;
  logic       ram_spo;
  logic       busy;

  ram128_arb_if bus();

  ram128_arb #(.INIT_VAL(INIT_VAL)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .ram_we  (ram_we),
    .ram_a   (ram_a),
    .ram_d   (ram_d),
    .ram_spo (ram_spo),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // The RAM the arbiter controls.
  logic ram_mem [128];
  always @(posedge clk) if (ram_we) ram_mem[ram_a] <= ram_d;
  assign ram_spo = ram_mem[ram_a];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model.
  bit m_mem [128];
  bit m_b_first;        // 1: B wins the next tie
  bit e_arv, e_brv;     // rvalid expected this cycle
  bit e_ard, e_brd;     // rdata expected this cycle

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit ar, input bit aw, input bit [6:0] aa, input bit ad,
                       input bit br, input bit bw, input bit [6:0] ba, input bit bd);
    bus.a_req = ar; bus.a_we = aw; bus.a_addr = aa; bus.a_wd = ad;
    bus.b_req = br; bus.b_we = bw; bus.b_addr = ba; bus.b_wd = bd;
  endtask

  // One serving cycle: apply inputs, compare everything against the model,
  // then advance the model across the closing edge.
  task automatic step(input bit ar, input bit aw, input bit [6:0] aa, input bit ad,
                      input bit br, input bit bw, input bit [6:0] ba, input bit bd,
                      output bit ga, output bit gb);
    bit ea, eb;
    drive(ar, aw, aa, ad, br, bw, ba, bd);
    ea = ar && (!br || !m_b_first);
    eb = br && (!ar ||  m_b_first);
    @(negedge clk);
    check("a_gnt", bus.a_gnt, ea);
    check("b_gnt", bus.b_gnt, eb);
    check("busy", busy, 0);
    check("a_rvalid", bus.a_rvalid, e_arv);
    check("b_rvalid", bus.b_rvalid, e_brv);
    check("a_rdata", bus.a_rdata, e_ard);
    check("b_rdata", bus.b_rdata, e_brd);
    if (ea) begin
      check("ram_we_a", ram_we, aw);
      check("ram_a_a", ram_a, aa);
      if (aw) check("ram_d_a", ram_d, ad);
    end else if (eb) begin
      check("ram_we_b", ram_we, bw);
      check("ram_a_b", ram_a, ba);
      if (bw) check("ram_d_b", ram_d, bd);
    end else begin
      check("ram_we_idle", ram_we, 0);
      check("ram_a_idle", ram_a, 0);
    end
    e_arv = ea && !aw;
    e_brv = eb && !bw;
    if (e_arv) e_ard = m_mem[aa];
    if (e_brv) e_brd = m_mem[ba];
    if (ea && aw) m_mem[aa] = ad;
    if (eb && bw) m_mem[ba] = bd;
    if (ea)      m_b_first = 1'b1;
    else if (eb) m_b_first = 1'b0;
    ga = ea;
    gb = eb;
    @(posedge clk);
    #1;
  endtask

  // Assert reset, check reset values immediately, hold, release.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy, INIT_ON);
    check("rst_a_gnt", bus.a_gnt, 0);
    check("rst_b_gnt", bus.b_gnt, 0);
    check("rst_a_rvalid", bus.a_rvalid, 0);
    check("rst_b_rvalid", bus.b_rvalid, 0);
    check("rst_a_rdata", bus.a_rdata, 0);
    check("rst_b_rdata", bus.b_rdata, 0);
    check("rst_ram_a", ram_a, 0);
    check("rst_ram_we", ram_we, INIT_ON);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_b_first = 1'b0;
    e_arv = 1'b0; e_brv = 1'b0;
    e_ard = 1'b0; e_brd = 1'b0;
  endtask

  // Init sweep: 128 cycles writing INIT_VAL at addresses 0..127. Returns early
  // (mid-cycle) at stop_at; raises a read request on A from cycle req_from.
  task automatic sweep(input int stop_at, input int req_from);
    for (int i = 0; i < 128; i++) begin
      if (i == req_from) begin
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 7'h15; bus.a_wd = 1'b0;
      end
      @(negedge clk);
      check("init_busy", busy, 1);
      check("init_ram_we", ram_we, 1);
      check("init_ram_a", ram_a, i);
      check("init_ram_d", ram_d, INIT_VAL);
      check("init_a_gnt", bus.a_gnt, 0);
      check("init_b_gnt", bus.b_gnt, 0);
      if (i == stop_at) return;
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 128; k++) m_mem[k] = INIT_VAL;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit ga, gb;
    bit ap, aw, ad, bp, bw, bd;
    bit [6:0] aa, ba;

    drive(0, 0, 7'd0, 0, 0, 0, 7'd0, 0);
    do_reset();

`ifdef RAM128_ARB_INIT_EN
    // Abort the sweep at cnt=50, then a full sweep with A requesting from cycle 10.
    sweep(50, 999);
    do_reset();
    sweep(999, 10);
    step(1, 0, 7'h15, 0, 0, 0, 7'd0, 0, ga, gb);  // first SERVE cycle: granted
    step(0, 0, 7'd0, 0, 0, 0, 7'd0, 0, ga, gb);   // exactly one grant
`else
    // Contents are unknown after reset: preload every address, alternating sides.
    for (int i = 0; i < 128; i++) begin
      if (i % 2 == 0) step(1, 1, 7'(i), 1'($urandom_range(0, 1)), 0, 0, 7'd0, 0, ga, gb);
      else            step(0, 0, 7'd0, 0, 1, 1, 7'(i), 1'($urandom_range(0, 1)), ga, gb);
    end
`endif

    // Single requester: write 0x15=1, read it back next cycle.
    step(1, 1, 7'h15, 1, 0, 0, 7'd0, 0, ga, gb);
    step(1, 0, 7'h15, 0, 0, 0, 7'd0, 0, ga, gb);
    step(0, 0, 7'd0, 0, 0, 0, 7'd0, 0, ga, gb);
    check("single_rdata_one", bus.a_rdata, 1);

    // B alone so the next tie goes to A, then six cycles of contention.
    step(0, 0, 7'd0, 0, 1, 1, 7'h40, 1, ga, gb);
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 7'h15, 0, 1, 0, 7'h40, 0, ga, gb);
      check("contention_order", {ga, gb}, (i % 2 == 0) ? 2'b10 : 2'b01);
    end
    step(0, 0, 7'd0, 0, 0, 0, 7'd0, 0, ga, gb);

    // Cross-requester coherence: B writes 0x7F=1, A reads it next cycle.
    step(0, 0, 7'd0, 0, 1, 1, 7'h7F, 1, ga, gb);
    step(1, 0, 7'h7F, 0, 0, 0, 7'd0, 0, ga, gb);
    step(0, 0, 7'd0, 0, 0, 0, 7'd0, 0, ga, gb);
    check("coherence_a_rdata", bus.a_rdata, 1);

    // Random traffic; each side holds its request until granted.
    ap = 0; bp = 0; aw = 0; bw = 0; ad = 0; bd = 0; aa = '0; ba = '0;
    for (int n = 0; n < 400; n++) begin
      if (!ap) begin
        ap = ($urandom_range(0, 3) != 0);
        aw = 1'($urandom_range(0, 1));
        ad = 1'($urandom_range(0, 1));
        aa = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 7)) : 7'($urandom_range(0, 127));
      end
      if (!bp) begin
        bp = ($urandom_range(0, 3) != 0);
        bw = 1'($urandom_range(0, 1));
        bd = 1'($urandom_range(0, 1));
        ba = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 7)) : 7'($urandom_range(0, 127));
      end
      step(ap, aw, aa, ad, bp, bw, ba, bd, ga, gb);
      if (ga) ap = 0;
      if (gb) bp = 0;
    end
    step(0, 0, 7'd0, 0, 0, 0, 7'd0, 0, ga, gb);

    // Reset in the middle of a read transaction: no rvalid pulse afterwards,
    // rdata cleared, tie goes back to A.
    step(1, 1, 7'h15, 1, 0, 0, 7'd0, 0, ga, gb);
    step(1, 0, 7'h15, 0, 0, 0, 7'd0, 0, ga, gb);
    drive(1, 0, 7'h15, 0, 1, 0, 7'h22, 0);
    @(negedge clk);
    do_reset();
`ifdef RAM128_ARB_INIT_EN
    sweep(999, 999);
`endif
    step(1, 0, 7'h15, 0, 1, 0, 7'h22, 0, ga, gb);
    step(0, 0, 7'd0, 0, 1, 0, 7'h22, 0, ga, gb);
    step(0, 0, 7'd0, 0, 0, 0, 7'd0, 0, ga, gb);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
